// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port 0 (MEM stage) has fixed
// priority, port 1 (loader/debug) is protected by an aging counter that forces a grant.
module dmem_arbiter #(
   parameter int DEPTH    = 8000,
   parameter int MAX_WAIT = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             p0_req,
   input  logic                             p0_we,
   input  logic [31:0]                      p0_addr,
   input  logic [31:0]                      p0_wdata,
   output logic                             p0_gnt,
   output logic                             p0_stall,
   output logic                             p0_ack,
   output logic                             p0_err,
   output logic [31:0]                      p0_rdata,
   input  logic                             p1_req,
   input  logic                             p1_we,
   input  logic [31:0]                      p1_addr,
   input  logic [31:0]                      p1_wdata,
   output logic                             p1_gnt,
   output logic                             p1_stall,
   output logic                             p1_ack,
   output logic                             p1_err,
   output logic [31:0]                      p1_rdata,
   output logic [31:0]                      mem_addr,
   output logic [31:0]                      mem_wdata,
   output logic                             mem_read,
   output logic                             mem_write,
   input  logic [31:0]                      mem_rdata,
   output logic                             dbg_state,
   output logic [$clog2(MAX_WAIT+1)-1:0]    dbg_wait_cnt
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [0:0] P0_PRI   = 1'b0;
   localparam logic [0:0] P1_FORCE = 1'b1;

   // Handshake: a transfer fires in any cycle with req & gnt; its ack/err/rdata are
   // presented for exactly the following cycle. Holding req is a new transaction.

   logic [0:0]    state, state_nx;
   logic [WW-1:0] wait_cnt, wait_nx;
   logic          any_gnt, sel_we, sel_bad;
   logic [31:0]   sel_addr, sel_wdata;

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
   endfunction

   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (state == P1_FORCE) begin
         p1_gnt = p1_req;
         p0_gnt = p0_req & ~p1_req;
      end else begin
         p0_gnt = p0_req;
         p1_gnt = p1_req & ~p0_req;
      end
   end

   assign p0_stall = p0_req & ~p0_gnt;
   assign p1_stall = p1_req & ~p1_gnt;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (p0_gnt) begin
         sel_we    = p0_we;
         sel_addr  = p0_addr;
         sel_wdata = p0_wdata;
      end else if (p1_gnt) begin
         sel_we    = p1_we;
         sel_addr  = p1_addr;
         sel_wdata = p1_wdata;
      end
   end

   assign any_gnt   = p0_gnt | p1_gnt;
   assign sel_bad   = addr_bad(sel_addr);
   assign mem_addr  = sel_addr;
   assign mem_wdata = sel_wdata;
   // Strobes are gated by rst_n so nothing reaches memory while reset is held.
   assign mem_read  = rst_n & any_gnt & ~sel_we & ~sel_bad;
   assign mem_write = rst_n & any_gnt &  sel_we & ~sel_bad;

   always_comb begin
      if (!p1_req || p1_gnt)
         wait_nx = '0;
      else if (wait_cnt < WW'(MAX_WAIT))
         wait_nx = wait_cnt + WW'(1);
      else
         wait_nx = wait_cnt;
   end

   always_comb begin
      state_nx = state;
      case (state)
         P0_PRI:   if (wait_nx == WW'(MAX_WAIT)) state_nx = P1_FORCE;
         P1_FORCE: if (p1_gnt || !p1_req)        state_nx = P0_PRI;
         default:  state_nx = P0_PRI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= P0_PRI;
         wait_cnt <= '0;
         p0_ack   <= 1'b0;
         p0_err   <= 1'b0;
         p0_rdata <= '0;
         p1_ack   <= 1'b0;
         p1_err   <= 1'b0;
         p1_rdata <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         p0_ack   <= p0_gnt;
         p0_err   <= p0_gnt & sel_bad;
         p0_rdata <= (p0_gnt & mem_read) ? mem_rdata : '0;
         p1_ack   <= p1_gnt;
         p1_err   <= p1_gnt & sel_bad;
         p1_rdata <= (p1_gnt & mem_read) ? mem_rdata : '0;
      end
   end

   assign dbg_state    = state;
   assign dbg_wait_cnt = wait_cnt;

endmodule
